// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the multicycle PC control FSM: states, instruction classes,
// next-PC selects and the interrupt vector address.
package pc_ctrl_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_INT    = 3'd5;

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_BRANCH = 3'd1;
    localparam logic [2:0] CLS_JUMP   = 3'd2;
    localparam logic [2:0] CLS_JR     = 3'd3;
    localparam logic [2:0] CLS_LOAD   = 3'd4;
    localparam logic [2:0] CLS_STORE  = 3'd5;
    localparam logic [2:0] CLS_ERET   = 3'd6;
    localparam logic [2:0] CLS_UNDEF  = 3'd7;

    localparam logic [2:0] NPC_SEQ    = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JR     = 3'b011;
    localparam logic [2:0] NPC_VECTOR = 3'b100;
    localparam logic [2:0] NPC_EPC    = 3'b101;

    localparam logic [31:0] INT_VECTOR = 32'h0000_4180;

    // Unused encodings 6/7 behave as FETCH so a corrupted state self-recovers.
    function automatic logic [2:0] norm_state(input logic [2:0] s);
        return (s > S_INT) ? S_FETCH : s;
    endfunction

endpackage

// File: rtl/pc_ctrl_outdec.sv
// Combinational output decode for pc_ctrl_fsm: all enables are pulses derived
// from the current state and inputs. INT_EN mirrors the PC_CTRL_INT_EN build option.
import pc_ctrl_pkg::*;

module pc_ctrl_outdec #(
    parameter bit INT_EN = 1'b0
) (
    input  logic       i_rst,
    input  logic [2:0] i_state,
    input  logic [2:0] i_cls,
    input  logic       i_br_taken,
    input  logic       i_imem_rdy,
    input  logic       i_int_take,
    output logic [2:0] o_npc_op,
    output logic       o_pc_we,
    output logic       o_ir_we,
    output logic       o_rf_we,
    output logic       o_epc_we,
    output logic       o_imem_req,
    output logic       o_dmem_req,
    output logic       o_dmem_wr
);

    always_comb begin
        o_npc_op   = NPC_SEQ;
        o_pc_we    = 1'b0;
        o_ir_we    = 1'b0;
        o_rf_we    = 1'b0;
        o_epc_we   = 1'b0;
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_dmem_wr  = 1'b0;
        if (!i_rst) begin
            case (i_state)
                // A pending interrupt withdraws the fetch request, even if imem_rdy arrives.
                S_FETCH: begin
                    if (!i_int_take) begin
                        o_imem_req = 1'b1;
                        if (i_imem_rdy) begin
                            o_ir_we = 1'b1;
                            o_pc_we = 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    case (i_cls)
                        CLS_BRANCH: begin
                            o_npc_op = NPC_BRANCH;
                            o_pc_we  = i_br_taken;
                        end
                        CLS_JUMP: begin
                            o_npc_op = NPC_JUMP;
                            o_pc_we  = 1'b1;
                        end
                        CLS_JR: begin
                            o_npc_op = NPC_JR;
                            o_pc_we  = 1'b1;
                        end
                        CLS_ERET: begin
                            if (INT_EN) begin
                                o_npc_op = NPC_EPC;
                                o_pc_we  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    o_dmem_req = 1'b1;
                    o_dmem_wr  = (i_cls == CLS_STORE);
                end
                S_WB: o_rf_we = 1'b1;
                S_INT: begin
                    o_npc_op = NPC_VECTOR;
                    o_pc_we  = 1'b1;
                    o_epc_we = INT_EN;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pc_ctrl_fsm.sv
// Multicycle PC control FSM: state and exception-level registers, outputs decoded
// by pc_ctrl_outdec. Define PC_CTRL_INT_EN to build in interrupt/ERET support.
import pc_ctrl_pkg::*;

module pc_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cls,
    input  logic       br_taken,
    input  logic       imem_rdy,
    input  logic       dmem_rdy,
    input  logic       int_req,
    output logic [2:0] npc_op,
    output logic       pc_we,
    output logic       ir_we,
    output logic       rf_we,
    output logic       epc_we,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_wr,
    output logic       exl,
    output logic [2:0] state
);

`ifdef PC_CTRL_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic [2:0] r_state;
    logic [2:0] w_state;
    logic [2:0] w_next_state;
    logic       w_int_take;

    assign w_state = norm_state(r_state);
    assign state   = r_state;

`ifdef PC_CTRL_INT_EN
    logic r_exl;

    // int_req is a level and is not latched; while exl is set it simply waits.
    assign w_int_take = int_req & ~r_exl;
    assign exl        = r_exl;

    always_ff @(posedge clk) begin
        if (rst)
            r_exl <= 1'b0;
        else if (w_state == S_INT)
            r_exl <= 1'b1;
        else if (w_state == S_EXEC && cls == CLS_ERET)
            r_exl <= 1'b0;
    end
`else
    logic w_unused_int_req;

    assign w_unused_int_req = int_req;
    assign w_int_take       = 1'b0;
    assign exl              = 1'b0;
`endif

    always_comb begin
        w_next_state = S_FETCH;
        case (w_state)
            S_FETCH: begin
                if (w_int_take)
                    w_next_state = S_INT;
                else if (imem_rdy)
                    w_next_state = S_DECODE;
                else
                    w_next_state = S_FETCH;
            end
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                case (cls)
                    CLS_ALU:              w_next_state = S_WB;
                    CLS_LOAD, CLS_STORE:  w_next_state = S_MEM;
                    default:              w_next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (!dmem_rdy)
                    w_next_state = S_MEM;
                else if (cls == CLS_LOAD)
                    w_next_state = S_WB;
                else
                    w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_FETCH;
        else
            r_state <= w_next_state;
    end

    pc_ctrl_outdec #(
        .INT_EN(INT_EN)
    ) u_outdec (
        .i_rst      (rst),
        .i_state    (w_state),
        .i_cls      (cls),
        .i_br_taken (br_taken),
        .i_imem_rdy (imem_rdy),
        .i_int_take (w_int_take),
        .o_npc_op   (npc_op),
        .o_pc_we    (pc_we),
        .o_ir_we    (ir_we),
        .o_rf_we    (rf_we),
        .o_epc_we   (epc_we),
        .o_imem_req (imem_req),
        .o_dmem_req (dmem_req),
        .o_dmem_wr  (dmem_wr)
    );

endmodule

// File: tb/tb_pc_ctrl_fsm.sv
// Scoreboard bench for pc_ctrl_fsm: directed per-cycle vectors push expectations,
// a negedge monitor pops and compares. Interrupt vectors follow PC_CTRL_INT_EN.
import pc_ctrl_pkg::*;

module tb_pc_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [2:0] cls;
    logic       br_taken;
    logic       imem_rdy;
    logic       dmem_rdy;
    logic       int_req;
    logic [2:0] npc_op;
    logic       pc_we;
    logic       ir_we;
    logic       rf_we;
    logic       epc_we;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_wr;
    logic       exl;
    logic [2:0] state;

    typedef struct {
        string      tag;
        logic [2:0] state;
        logic [2:0] npc;
        logic [7:0] en;
    } exp_t;

    exp_t sbQueue[$];
    int   vectorCount = 0;
    int   missCount   = 0;

    pc_ctrl_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .cls      (cls),
        .br_taken (br_taken),
        .imem_rdy (imem_rdy),
        .dmem_rdy (dmem_rdy),
        .int_req  (int_req),
        .npc_op   (npc_op),
        .pc_we    (pc_we),
        .ir_we    (ir_we),
        .rf_we    (rf_we),
        .epc_we   (epc_we),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .dmem_wr  (dmem_wr),
        .exl      (exl),
        .state    (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected enable vector layout: {pc_we, ir_we, rf_we, epc_we, imem_req, dmem_req, dmem_wr, exl}.
    task automatic applyStimulus(input string tag, input logic iRst, input logic [2:0] iCls,
                                 input logic iBr, input logic iIrdy, input logic iDrdy,
                                 input logic iInt, input logic [2:0] eState,
                                 input logic [2:0] eNpc, input logic [7:0] eEn);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = iRst;
        cls      = iCls;
        br_taken = iBr;
        imem_rdy = iIrdy;
        dmem_rdy = iDrdy;
        int_req  = iInt;
        e.tag    = tag;
        e.state  = eState;
        e.npc    = eNpc;
        e.en     = eEn;
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [7:0] gotEn;
        gotEn = {pc_we, ir_we, rf_we, epc_we, imem_req, dmem_req, dmem_wr, exl};
        vectorCount++;
        if (state !== e.state || npc_op !== e.npc || gotEn !== e.en) begin
            missCount++;
            $display("[TB] FAIL %s: got state=%0d npc_op=%b en=%b, expected state=%0d npc_op=%b en=%b",
                     e.tag, state, npc_op, gotEn, e.state, e.npc, e.en);
        end
    endtask

    always @(negedge clk) begin
        if (sbQueue.size() > 0)
            checkOutput(sbQueue.pop_front());
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; cls = CLS_ALU; br_taken = 1'b0;
        imem_rdy = 1'b0; dmem_rdy = 1'b0; int_req = 1'b0;

        applyStimulus("rst0",    1, CLS_ALU,    0, 1, 1, 0, S_FETCH,  NPC_SEQ,    8'b0000_0000);
        applyStimulus("rst1",    1, CLS_ALU,    0, 0, 0, 0, S_FETCH,  NPC_SEQ,    8'b0000_0000);

        applyStimulus("alu_f",   0, CLS_ALU,    0, 1, 0, 0, S_FETCH,  NPC_SEQ,    8'b1100_1000);
        applyStimulus("alu_d",   0, CLS_ALU,    0, 1, 1, 0, S_DECODE, NPC_SEQ,    8'b0000_0000);
        applyStimulus("alu_e",   0, CLS_ALU,    0, 0, 0, 0, S_EXEC,   NPC_SEQ,    8'b0000_0000);
        applyStimulus("alu_w",   0, CLS_ALU,    0, 0, 0, 0, S_WB,     NPC_SEQ,    8'b0010_0000);
        applyStimulus("wait_f",  0, CLS_ALU,    0, 0, 0, 0, S_FETCH,  NPC_SEQ,    8'b0000_1000);

        applyStimulus("br1_f",   0, CLS_BRANCH, 0, 1, 0, 0, S_FETCH,  NPC_SEQ,    8'b1100_1000);
        applyStimulus("br1_d",   0, CLS_BRANCH, 0, 0, 0, 0, S_DECODE, NPC_SEQ,    8'b0000_0000);
        applyStimulus("br1_e",   0, CLS_BRANCH, 1, 0, 0, 0, S_EXEC,   NPC_BRANCH, 8'b1000_0000);
        applyStimulus("br0_f",   0, CLS_BRANCH, 1, 1, 0, 0, S_FETCH,  NPC_SEQ,    8'b1100_1000);
        applyStimulus("br0_d",   0, CLS_BRANCH, 1, 0, 0, 0, S_DECODE, NPC_SEQ,    8'b0000_0000);
        applyStimulus("br0_e",   0, CLS_BRANCH, 0, 0, 0, 0, S_EXEC,   NPC_BRANCH, 8'b0000_0000);

        applyStimulus("jmp_f",   0, CLS_JUMP,   0, 1, 0, 0, S_FETCH,  NPC_SEQ,    8'b1100_1000);
        applyStimulus("jmp_d",   0, CLS_JUMP,   0, 0, 0, 0, S_DECODE, NPC_SEQ,    8'b0000_0000);
        applyStimulus("jmp_e",   0, CLS_JUMP,   0, 0, 0, 0, S_EXEC,   NPC_JUMP,   8'b1000_0000);
        applyStimulus("jr_f",    0, CLS_JR,     0, 1, 0, 0, S_FETCH,  NPC_SEQ,    8'b1100_1000);
        applyStimulus("jr_d",    0, CLS_JR,     0, 0, 0, 0, S_DECODE, NPC_SEQ,    8'b0000_0000);
        applyStimulus("jr_e",    0, CLS_JR,     0, 0, 0, 0, S_EXEC,   NPC_JR,     8'b1000_0000);
        applyStimulus("und_f",   0, CLS_UNDEF,  0, 1, 0, 0, S_FETCH,  NPC_SEQ,    8'b1100_1000);
        applyStimulus("und_d",   0, CLS_UNDEF,  0, 0, 0, 0, S_DECODE, NPC_SEQ,    8'b0000_0000);
        applyStimulus("und_e",   0, CLS_UNDEF,  1, 0, 0, 0, S_EXEC,   NPC_SEQ,    8'b0000_0000);

        applyStimulus("ld_f",    0, CLS_LOAD,   0, 1, 0, 0, S_FETCH,  NPC_SEQ,    8'b1100_1000);
        applyStimulus("ld_d",    0, CLS_LOAD,   0, 0, 1, 0, S_DECODE, NPC_SEQ,    8'b0000_0000);
        applyStimulus("ld_e",    0, CLS_LOAD,   0, 0, 0, 0, S_EXEC,   NPC_SEQ,    8'b0000_0000);
        applyStimulus("ld_m0",   0, CLS_LOAD,   0, 1, 0, 0, S_MEM,    NPC_SEQ,    8'b0000_0100);
        applyStimulus("ld_m1",   0, CLS_LOAD,   0, 0, 0, 0, S_MEM,    NPC_SEQ,    8'b0000_0100);
        applyStimulus("ld_m2",   0, CLS_LOAD,   0, 0, 0, 0, S_MEM,    NPC_SEQ,    8'b0000_0100);
        applyStimulus("ld_m3",   0, CLS_LOAD,   0, 0, 1, 0, S_MEM,    NPC_SEQ,    8'b0000_0100);
        applyStimulus("ld_w",    0, CLS_LOAD,   0, 0, 0, 0, S_WB,     NPC_SEQ,    8'b0010_0000);

        applyStimulus("st_f",    0, CLS_STORE,  0, 1, 0, 0, S_FETCH,  NPC_SEQ,    8'b1100_1000);
        applyStimulus("st_d",    0, CLS_STORE,  0, 0, 0, 0, S_DECODE, NPC_SEQ,    8'b0000_0000);
        applyStimulus("st_e",    0, CLS_STORE,  0, 0, 0, 0, S_EXEC,   NPC_SEQ,    8'b0000_0000);
        applyStimulus("st_m",    0, CLS_STORE,  0, 0, 1, 0, S_MEM,    NPC_SEQ,    8'b0000_0110);

        applyStimulus("rm_f",    0, CLS_LOAD,   0, 1, 0, 0, S_FETCH,  NPC_SEQ,    8'b1100_1000);
        applyStimulus("rm_d",    0, CLS_LOAD,   0, 0, 0, 0, S_DECODE, NPC_SEQ,    8'b0000_0000);
        applyStimulus("rm_e",    0, CLS_LOAD,   0, 0, 0, 0, S_EXEC,   NPC_SEQ,    8'b0000_0000);
        applyStimulus("rm_m",    0, CLS_LOAD,   0, 0, 0, 0, S_MEM,    NPC_SEQ,    8'b0000_0100);
        applyStimulus("rm_rst",  1, CLS_LOAD,   0, 0, 1, 0, S_MEM,    NPC_SEQ,    8'b0000_0000);
        applyStimulus("rm_post", 0, CLS_LOAD,   0, 0, 0, 0, S_FETCH,  NPC_SEQ,    8'b0000_1000);

`ifdef PC_CTRL_INT_EN
        applyStimulus("int_f",   0, CLS_ALU,    0, 1, 0, 1, S_FETCH,  NPC_SEQ,    8'b0000_0000);
        applyStimulus("int_i",   0, CLS_ALU,    0, 1, 0, 1, S_INT,    NPC_VECTOR, 8'b1001_0000);
        applyStimulus("hold_f",  0, CLS_ALU,    0, 0, 0, 1, S_FETCH,  NPC_SEQ,    8'b0000_1001);
        applyStimulus("er_f",    0, CLS_ERET,   0, 1, 0, 1, S_FETCH,  NPC_SEQ,    8'b1100_1001);
        applyStimulus("er_d",    0, CLS_ERET,   0, 0, 0, 1, S_DECODE, NPC_SEQ,    8'b0000_0001);
        applyStimulus("er_e",    0, CLS_ERET,   0, 0, 0, 0, S_EXEC,   NPC_EPC,    8'b1000_0001);
        applyStimulus("er_post", 0, CLS_ALU,    0, 0, 0, 0, S_FETCH,  NPC_SEQ,    8'b0000_1000);
        applyStimulus("ri_f",    0, CLS_ALU,    0, 0, 0, 1, S_FETCH,  NPC_SEQ,    8'b0000_0000);
        applyStimulus("ri_i",    0, CLS_ALU,    0, 0, 0, 0, S_INT,    NPC_VECTOR, 8'b1001_0000);
        applyStimulus("ri_rst",  1, CLS_ALU,    0, 1, 0, 1, S_FETCH,  NPC_SEQ,    8'b0000_0001);
        applyStimulus("ri_post", 0, CLS_ALU,    0, 0, 0, 0, S_FETCH,  NPC_SEQ,    8'b0000_1000);
`else
        applyStimulus("nint_f",  0, CLS_ERET,   0, 1, 0, 1, S_FETCH,  NPC_SEQ,    8'b1100_1000);
        applyStimulus("nint_d",  0, CLS_ERET,   0, 0, 0, 1, S_DECODE, NPC_SEQ,    8'b0000_0000);
        applyStimulus("nint_e",  0, CLS_ERET,   0, 0, 0, 1, S_EXEC,   NPC_SEQ,    8'b0000_0000);
        applyStimulus("nint_w",  0, CLS_ALU,    0, 0, 0, 1, S_FETCH,  NPC_SEQ,    8'b0000_1000);
`endif

        repeat (3) @(posedge clk);
        if (sbQueue.size() != 0) begin
            missCount++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", sbQueue.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
